// File: rtl/jtag_uart_pkg.sv
// Shared types and register map for the JTAG UART byte bridge.
package jtag_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_CTRL,
        ST_WR_DATA,
        ST_RD_DATA
    } state_t;

    localparam logic ADDR_DATA  = 1'b0;
    localparam logic ADDR_CTRL  = 1'b1;
    localparam int   WSPACE_LSB = 16;
    localparam int   RVALID_BIT = 15;

    function automatic logic [31:0] pack_wdata(input logic [7:0] b);
        return {24'b0, b};
    endfunction

endpackage

// File: rtl/jtag_uart_tx_fifo.sv
// Synchronous circular-buffer FIFO holding bytes waiting for the JTAG UART.
module jtag_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_head
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    // A push into a full buffer is discarded even if a pop happens the same cycle.
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_full    = (r_count == CNT_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jtag_uart_bridge.sv
// Byte-stream bridge: strobe-driven TX queue drained into an Avalon-MM JTAG UART,
// with RX polling of the data register whenever nothing is waiting to go out.
module jtag_uart_bridge
    import jtag_uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_50,
    input  logic        RESET,
    input  logic        WR_STROBE,
    input  logic [7:0]  WR_DATA,
    output logic [7:0]  READ_DATA,
    output logic        RX_VALID,
    output logic        TX_OVERFLOW,
    output logic        av_chipselect,
    output logic        av_address,
    output logic        av_read_n,
    output logic        av_write_n,
    output logic [31:0] av_writedata,
    input  logic [31:0] av_readdata,
    input  logic        av_waitrequest
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   r_overflow;
    state_t                 r_state;
    logic                   r_cs;
    logic                   r_addr;
    logic                   r_rd_n;
    logic                   r_wr_n;
    logic [31:0]            r_wdata;
    logic [7:0]             r_rdata;
    logic                   r_rx_valid;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;
    logic       w_wspace;
    logic       w_rvalid;
    logic       w_unused;

    // Flops reset high so a strobe already high at reset release is not an edge.
    always_ff @(posedge CLK_50 or negedge RESET) begin
        if (!RESET) begin
            r_sync <= '1;
            r_edge <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], WR_STROBE};
            r_edge <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_push   = r_sync[SYNC_STAGES-1] && !r_edge;
    assign w_pop    = (r_state == ST_WR_DATA) && !av_waitrequest;
    assign w_wspace = |av_readdata[31:WSPACE_LSB];
    assign w_rvalid = av_readdata[RVALID_BIT];
    assign w_unused = ^av_readdata[14:8];

    jtag_uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (CLK_50),
        .i_rst_n (RESET),
        .i_push  (w_push),
        .i_data  (WR_DATA),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge CLK_50 or negedge RESET) begin
        if (!RESET) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Bus outputs are set on state entry and held until waitrequest drops.
    always_ff @(posedge CLK_50 or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_cs       <= 1'b0;
            r_addr     <= ADDR_DATA;
            r_rd_n     <= 1'b1;
            r_wr_n     <= 1'b1;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cs   <= 1'b1;
                    r_rd_n <= 1'b0;
                    if (!w_empty) begin
                        r_state <= ST_RD_CTRL;
                        r_addr  <= ADDR_CTRL;
                    end else begin
                        r_state <= ST_RD_DATA;
                        r_addr  <= ADDR_DATA;
                    end
                end
                ST_RD_CTRL: begin
                    if (!av_waitrequest) begin
                        r_rd_n <= 1'b1;
                        r_addr <= ADDR_DATA;
                        if (w_wspace) begin
                            r_state <= ST_WR_DATA;
                            r_wr_n  <= 1'b0;
                            r_wdata <= pack_wdata(w_head);
                        end else begin
                            r_state <= ST_IDLE;
                            r_cs    <= 1'b0;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (!av_waitrequest) begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b0;
                        r_wr_n  <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (!av_waitrequest) begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b0;
                        r_rd_n  <= 1'b1;
                        if (w_rvalid) begin
                            r_rdata    <= av_readdata[7:0];
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign av_chipselect = r_cs;
    assign av_address    = r_addr;
    assign av_read_n     = r_rd_n;
    assign av_write_n    = r_wr_n;
    assign av_writedata  = r_wdata;
    assign READ_DATA     = r_rdata;
    assign RX_VALID      = r_rx_valid;
    assign TX_OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_jtag_uart_bridge.sv
// Bench for jtag_uart_bridge: behavioural JTAG UART slave plus byte-stream reference model.
module tb_jtag_uart_bridge;

    logic        CLK_50 = 1'b0;
    logic        RESET = 1'b0;
    logic        WR_STROBE = 1'b1;
    logic [7:0]  WR_DATA = 8'h00;
    logic [7:0]  READ_DATA;
    logic        RX_VALID;
    logic        TX_OVERFLOW;
    logic        av_chipselect;
    logic        av_address;
    logic        av_read_n;
    logic        av_write_n;
    logic [31:0] av_writedata;
    wire  [31:0] av_readdata;
    logic        av_waitrequest = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    // Slave-side state: completions flagged at negedge, applied by the driver after posedge.
    int          cyc = 0, wr_active = 0, ctrl_polls = 0, rx_pulses = 0, wr_addr_bad = 0;
    logic [31:0] wr_log[$];
    int          wr_cyc[$];
    logic        mon_ctrl_done = 1'b0, mon_rx_done = 1'b0;
    int          ctrl_done_total = 0, nospace_until = 0, rx_ack_cnt = 0, rx_req_cnt = 0;
    logic [31:0] ctrl_val = 32'h0040_0000, ctrl_rand = 32'h0, noise_word = 32'h0, rx_word = 32'h0;
    bit          rand_ctrl = 1'b0, rand_wait = 1'b0;
    int          stall_cycles = 0;

    assign av_readdata = av_address ?
        ((ctrl_done_total < nospace_until) ? 32'h0 : (rand_ctrl ? ctrl_rand : ctrl_val)) :
        ((rx_req_cnt != rx_ack_cnt) ? rx_word : noise_word);

    jtag_uart_bridge #(
        .FIFO_DEPTH  (16),
        .SYNC_STAGES (2)
    ) dut (
        .CLK_50         (CLK_50),
        .RESET          (RESET),
        .WR_STROBE      (WR_STROBE),
        .READ_DATA      (READ_DATA),
        .WR_DATA        (WR_DATA),
        .RX_VALID       (RX_VALID),
        .TX_OVERFLOW    (TX_OVERFLOW),
        .av_chipselect  (av_chipselect),
        .av_address     (av_address),
        .av_read_n      (av_read_n),
        .av_write_n     (av_write_n),
        .av_writedata   (av_writedata),
        .av_readdata    (av_readdata),
        .av_waitrequest (av_waitrequest)
    );

    always #10 CLK_50 = ~CLK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus monitor
    initial begin
        forever begin
            @(negedge CLK_50);
            cyc++;
            mon_ctrl_done = RESET && av_chipselect && !av_read_n && av_address && !av_waitrequest;
            mon_rx_done   = RESET && av_chipselect && !av_read_n && !av_address && !av_waitrequest
                            && (rx_req_cnt != rx_ack_cnt);
            if (mon_ctrl_done) ctrl_polls++;
            if (RESET && av_chipselect && !av_write_n) begin
                wr_active++;
                if (av_address) wr_addr_bad++;
                if (!av_waitrequest) begin
                    wr_log.push_back(av_writedata);
                    wr_cyc.push_back(cyc);
                end
            end
            if (RESET && RX_VALID) rx_pulses++;
        end
    end

    // Slave response driver
    initial begin
        int rem;
        bit in_wr;
        rem = 0;
        in_wr = 1'b0;
        forever begin
            @(posedge CLK_50);
            #1;
            if (mon_ctrl_done) ctrl_done_total++;
            if (mon_rx_done) rx_ack_cnt++;
            ctrl_rand  = {($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535)),
                          16'($urandom)};
            noise_word = $urandom & 32'hFFFF_7FFF;
            if (av_chipselect && !av_write_n) begin
                if (!in_wr) begin
                    in_wr = 1'b1;
                    rem = stall_cycles;
                end
            end else begin
                in_wr = 1'b0;
            end
            if (rem > 0) begin
                av_waitrequest = 1'b1;
                rem--;
            end else begin
                av_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        @(negedge CLK_50);
        WR_DATA = b;
        WR_STROBE = 1'b1;
        repeat (hi) @(negedge CLK_50);
        WR_STROBE = 1'b0;
        repeat (lo) @(negedge CLK_50);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_log.size() < n; i++) @(negedge CLK_50);
        check("wr_count", wr_log.size(), n);
    endtask

    task automatic rx_send(input logic [31:0] w);
        @(posedge CLK_50);
        #2;
        rx_word = w;
        rx_req_cnt++;
    endtask

    task automatic wait_rx_ack(input int budget);
        for (int i = 0; i < budget && rx_ack_cnt != rx_req_cnt; i++) @(negedge CLK_50);
        check("rx_ack", rx_ack_cnt, rx_req_cnt);
    endtask

    initial begin
        int p, w, base, rp, exp_pulses, n;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_q[$];
        logic [7:0]  b;
        logic [31:0] word;

        // Reset with strobe held high
        repeat (3) @(negedge CLK_50);
        check("rst_cs", av_chipselect, 0);
        check("rst_rd_n", av_read_n, 1);
        check("rst_wr_n", av_write_n, 1);
        check("rst_addr", av_address, 0);
        check("rst_wdata", av_writedata, 0);
        check("rst_rdata", READ_DATA, 0);
        check("rst_rxv", RX_VALID, 0);
        check("rst_ovf", TX_OVERFLOW, 0);
        RESET = 1'b1;
        repeat (10) @(negedge CLK_50);
        check("rel_no_ctrl_poll", ctrl_polls, 0);
        check("rel_no_write", wr_active, 0);
        WR_STROBE = 1'b0;
        repeat (4) @(negedge CLK_50);

        // Single byte
        send_byte(8'h41, 4, 4);
        wait_writes(1, 50);
        check("single_wd", wr_log[0], 32'h0000_0041);
        p = ctrl_polls;
        repeat (10) @(negedge CLK_50);
        check("single_empty", ctrl_polls, p);
        check("single_no_dup", wr_log.size(), 1);

        // No write space for five polls
        nospace_until = ctrl_done_total + 5;
        p = ctrl_polls;
        send_byte(8'h42, 4, 4);
        wait_writes(2, 100);
        check("nospace_polls", ctrl_polls - p, 6);
        check("nospace_wd", wr_log[1], 32'h0000_0042);

        // Write stalled by waitrequest
        stall_cycles = 4;
        w = wr_active;
        @(negedge CLK_50);
        WR_DATA = 8'h43;
        WR_STROBE = 1'b1;
        for (int i = 0; i < 20 && !(av_chipselect && !av_write_n); i++) @(negedge CLK_50);
        check("stall_start", av_write_n, 0);
        for (int i = 0; i < 4; i++) begin
            check("stall_wait", av_waitrequest, 1);
            check("stall_addr", av_address, 0);
            check("stall_wd", av_writedata, 32'h0000_0043);
            check("stall_wr_n", av_write_n, 0);
            @(negedge CLK_50);
        end
        WR_STROBE = 1'b0;
        wait_writes(3, 50);
        stall_cycles = 0;
        repeat (10) @(negedge CLK_50);
        check("stall_cycles", wr_active - w, 5);
        check("stall_wd_log", wr_log[2], 32'h0000_0043);
        check("stall_one_pop", wr_log.size(), 3);

        // Overflow with no write space
        ctrl_val = 32'h0;
        for (int i = 0; i < 17; i++) begin
            if (i == 16) check("ovf_before", TX_OVERFLOW, 0);
            send_byte(8'(i), 4, 4);
        end
        check("ovf_set", TX_OVERFLOW, 1);
        base = wr_log.size();
        ctrl_val = 32'h0001_0000;
        wait_writes(base + 16, 300);
        for (int i = 0; i < 16; i++) check("ovf_order", wr_log[base + i], 32'(i));
        check("ovf_rate", wr_cyc[base + 15] - wr_cyc[base], 45);
        repeat (20) @(negedge CLK_50);
        check("ovf_dropped", wr_log.size(), base + 16);
        check("ovf_sticky", TX_OVERFLOW, 1);
        ctrl_val = 32'h0040_0000;

        // RX with and without RVALID
        rp = rx_pulses;
        rx_send(32'h0000_805A);
        for (int i = 0; i < 30 && !RX_VALID; i++) @(negedge CLK_50);
        check("rx_data", READ_DATA, 8'h5A);
        @(negedge CLK_50);
        check("rx_pulse_width", RX_VALID, 0);
        check("rx_pulse_count", rx_pulses - rp, 1);
        rx_send(32'h0000_0033);
        wait_rx_ack(30);
        repeat (3) @(negedge CLK_50);
        check("rx_norvalid_data", READ_DATA, 8'h5A);
        check("rx_norvalid_pulses", rx_pulses - rp, 1);

        // Randomized traffic against the byte-stream model
        rand_ctrl = 1'b1;
        rand_wait = 1'b1;
        exp_rd = 8'h5A;
        exp_pulses = rx_pulses;
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 12);
            base = wr_log.size();
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                send_byte(b, $urandom_range(3, 6), $urandom_range(3, 6));
            end
            wait_writes(base + n, 600);
            for (int k = 0; k < n; k++) check("rand_tx", wr_log[base + k], {24'b0, exp_q[k]});
            exp_q.delete();
            for (int k = 0; k < 3; k++) begin
                word = $urandom;
                rx_send(word);
                wait_rx_ack(80);
                repeat (2) @(negedge CLK_50);
                if (word[15]) begin
                    exp_rd = word[7:0];
                    exp_pulses++;
                end
                check("rand_rx_data", READ_DATA, exp_rd);
                check("rand_rx_pulses", rx_pulses, exp_pulses);
            end
        end

        check("write_addr", wr_addr_bad, 0);
        check("ovf_sticky_end", TX_OVERFLOW, 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/jtag_uart_bridge.md
Name: jtag_uart_bridge

Overview:
- Byte-stream bridge between slow debug logic and an Avalon-MM JTAG UART core (data register at word offset 0, control register at offset 1).
- Each rising edge of a level write strobe queues one byte into a TX FIFO. A polling FSM drains the FIFO into the core while host write space is available.
- The same FSM polls the core's data register and presents the last byte received from the host.
- Sits between the debug dump sequencer (byte serializer) and the JTAG UART core, all in the CLK_50 domain.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops on WR_STROBE; at least 2.

Ports:
- CLK_50  in  1  system clock; all logic on its rising edge.
- RESET  in  1  reset; asynchronous assert, active-low (0 = in reset).
- WR_STROBE  in  1  write strobe level, asynchronous/slow; each 0->1 transition enqueues WR_DATA.
- READ_DATA  out  8  last byte received from the host.
- WR_DATA  in  8  byte to transmit; must be stable while WR_STROBE rises.
- RX_VALID  out  1  one-cycle pulse when READ_DATA updates.
- TX_OVERFLOW  out  1  sticky; a push was dropped because the FIFO was full.
- av_chipselect  out  1  Avalon chip select.
- av_address  out  1  0 = data register, 1 = control register.
- av_read_n  out  1  active-low read.
- av_write_n  out  1  active-low write.
- av_writedata  out  32  write data.
- av_readdata  in  32  read data; valid in the cycle where waitrequest is low.
- av_waitrequest  in  1  slave stall.

Behaviour:
- Reset (RESET=0, async):
  - av_chipselect=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0.
  - READ_DATA=0x00, RX_VALID=0, TX_OVERFLOW=0.
  - FIFO empty; FSM in IDLE; all synchronizer and edge flops set to 1.
  - Reset mid-transaction aborts the bus cycle immediately.
- Strobe handling:
  - WR_STROBE passes through SYNC_STAGES flops, then a 1-cycle edge register.
  - Rising edge at the synchronizer output pushes WR_DATA, sampled in the same cycle as the push.
  - Push latency is SYNC_STAGES+1 clocks after the input rises.
  - Strobe held high across reset release does not push, because flops reset to 1.
- FIFO:
  - Circular buffer with wrap-around pointers and an occupancy counter of log2(FIFO_DEPTH)+1 bits.
  - Push when full: byte dropped, TX_OVERFLOW set until reset.
  - Simultaneous push and pop: both happen, occupancy unchanged.
  - Pop occurs only on completion of a data write.
- FSM states IDLE, RD_CTRL, WR_DATA, RD_DATA:
  - IDLE drives no bus cycle. Next state is RD_CTRL if the FIFO is non-empty, else RD_DATA.
  - RD_CTRL: chipselect=1, address=1, read_n=0. Hold while waitrequest=1. On the cycle with waitrequest=0: if av_readdata[31:16] (WSPACE) != 0, go to WR_DATA; else go to IDLE.
  - WR_DATA: chipselect=1, address=0, write_n=0, writedata = {24'b0, FIFO head}. Hold while waitrequest=1. On waitrequest=0: pop, go to IDLE.
  - RD_DATA: chipselect=1, address=0, read_n=0. Hold while waitrequest=1. On waitrequest=0: if av_readdata[15] (RVALID)=1, load READ_DATA <= av_readdata[7:0] and pulse RX_VALID next cycle; go to IDLE.
- Bus outputs are registered and constant for the whole duration of a bus cycle.
- With waitrequest=0, one byte is sent per 3 clocks (IDLE, RD_CTRL, WR_DATA).
- Pending TX bytes take priority over RX polling. RX is polled whenever the FIFO is empty.
- No byte is reordered, duplicated or lost unless an overflow is flagged.

Decomposition:
- Package jtag_uart_pkg: FSM state enum; register offset constants ADDR_DATA=0, ADDR_CTRL=1; bit positions WSPACE_LSB=16, RVALID_BIT=15.
- One sub-module jtag_uart_tx_fifo (synchronous FIFO, parameter FIFO_DEPTH, outputs full/empty/head).
- Synchronizer, edge detect and FSM live in the top level.

Test Plan:
- Reset: hold RESET=0 with WR_STROBE=1 -> all outputs at reset values. Release reset -> no push and no write cycle for 10 clocks.
- Single byte: WR_DATA=0x41, pulse WR_STROBE, slave returns ctrl=0x0040_0000, waitrequest=0 -> exactly one write at address 0 with writedata=0x0000_0041, FIFO empty afterwards.
- No space: ctrl returns WSPACE=0 for 5 polls, then 0x0001_0000 -> no write until the 6th poll, then the byte is written once.
- Waitrequest: hold waitrequest=1 for 4 cycles during WR_DATA -> address, writedata and write_n stable throughout, exactly one pop.
- Overflow: push 17 bytes 0x00..0x10 with WSPACE=0 -> TX_OVERFLOW=1. After WSPACE is opened, bytes 0x00..0x0F are written in order.
- RX: with FIFO empty, data read returns 0x0000_805A -> READ_DATA=0x5A and RX_VALID high for exactly 1 cycle. A return of 0x0000_0033 (RVALID=0) leaves READ_DATA unchanged.
